// File: rtl/pipe_reg.sv
// DEPTH-stage enabled pipeline register with per-stage valid bits and an occupancy count.
// Define PIPE_REG_ASSERT_EN to compile in the concurrent assertions.
module pipe_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    input  logic                         en,
    input  logic                         clr,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [DEPTH-1:0]            v_q, v_d;
    logic [OCC_W-1:0]            occ_q, occ_d;

    // Next-state: clear wins, then enabled shift, otherwise hold.
    always_comb begin
        stage_d = stage_q;
        v_d     = v_q;
        occ_d   = occ_q;
        if (clr) begin
            stage_d = {DEPTH{RESET_VAL}};
            v_d     = '0;
            occ_d   = '0;
        end else if (en) begin
            stage_d[0] = din_valid ? din : RESET_VAL;
            v_d[0]     = din_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                v_d[i]     = v_q[i-1];
            end
            occ_d = occ_q + OCC_W'(din_valid) - OCC_W'(v_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {DEPTH{RESET_VAL}};
            v_q     <= '0;
            occ_q   <= '0;
        end else begin
            stage_q <= stage_d;
            v_q     <= v_d;
            occ_q   <= occ_d;
        end
    end

    assign dout       = stage_q[DEPTH-1];
    assign dout_valid = v_q[DEPTH-1];
    assign occupancy  = occ_q;

`ifdef PIPE_REG_ASSERT_EN
    a_rst_out: assert property (@(posedge clk) rst |-> (dout == RESET_VAL && !dout_valid));
    a_hold:    assert property (@(posedge clk) disable iff (rst) (!en && !clr) |=> $stable(dout));
    a_occ_max: assert property (@(posedge clk) 32'(occ_q) <= DEPTH);
    a_occ_pop: assert property (@(posedge clk) int'($countones(v_q)) == int'(occ_q));
`else
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [2:0]       occupancy;

    int checks = 0;
    int errors = 0;

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .en(en), .clr(clr),
        .dout(dout), .dout_valid(dout_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference: queue front is the newest word, back is what dout must show.
    logic [WIDTH-1:0] md[$];
    bit               mv[$];

    function automatic int model_occ();
        int n = 0;
        foreach (mv[i]) n += int'(mv[i]);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            md.delete();
            mv.delete();
            for (int i = 0; i < int'(DEPTH); i++) begin
                md.push_back(8'h00);
                mv.push_back(1'b0);
            end
        end else if (en && md.size() == DEPTH) begin
            md.push_front(din_valid ? din : 8'h00);
            mv.push_front(din_valid);
            void'(md.pop_back());
            void'(mv.pop_back());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (md.size() == DEPTH) begin
            chk("model_dout", int'(dout), int'(md[DEPTH-1]));
            chk("model_dout_valid", int'(dout_valid), int'(mv[DEPTH-1]));
            chk("model_occupancy", int'(occupancy), model_occ());
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit dv, input logic [WIDTH-1:0] d, input bit c);
        en = e; din_valid = dv; din = d; clr = c;
    endtask

    task automatic expect_out(input string name, input int d, input int dv, input int occ);
        chk({name, "_dout"}, int'(dout), d);
        chk({name, "_valid"}, int'(dout_valid), dv);
        chk({name, "_occ"}, int'(occupancy), occ);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        edge1();
        edge1();
        expect_out("reset", 0, 0, 0);
        rst = 1'b0;

        // Single word: appears exactly on the 4th enabled edge.
        drive(1'b1, 1'b1, 8'hA5, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            edge1();
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            expect_out($sformatf("single_e%0d", e), (e == 4) ? 'hA5 : 0,
                       (e == 4) ? 1 : 0, (e <= 4) ? 1 : 0);
        end

        // Stream 1..4, then stall for three cycles.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b0);
            edge1();
        end
        expect_out("stream_full", 'h01, 1, 4);
        drive(1'b0, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge1();
            expect_out($sformatf("stall_%0d", i), 'h01, 1, 4);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        edge1();
        expect_out("resume", 'h02, 1, 3);

        // Refill, then clear with en low.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
            edge1();
        end
        expect_out("refill", 'h10, 1, 4);
        drive(1'b0, 1'b1, 8'h77, 1'b1);
        edge1();
        expect_out("clear", 0, 0, 0);

        // Async reset between edges with three words in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'(8'h21 + i), 1'b0);
            edge1();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pre_rst_occ", int'(occupancy), 3);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0);
        #1 rst = 1'b0;

        // Alternating valid.
        for (int e = 1; e <= 8; e++) begin
            if (e <= 4) drive(1'b1, (e % 2) == 1, 8'(8'h11 * e), 1'b0);
            else        drive(1'b1, 1'b0, 8'h00, 1'b0);
            edge1();
            checks++;
            if (occupancy > 3'd2) begin
                errors++;
                $display("FAIL alt_occ_max: got %0d expected <=2", occupancy);
            end
            if (e >= 4 && e <= 7) begin
                expect_out($sformatf("alt_e%0d", e), ((e % 2) == 0) ? 8'h11 * (e - 3) : 0,
                           ((e % 2) == 0) ? 1 : 0, int'(occupancy));
            end
        end

        // Randomized traffic including clear and async reset pulses.
        for (int n = 0; n < 1000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  8'($urandom), $urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 63) == 0);
            edge1();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        edge1();
        edge1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
